// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage RV32 pipeline.
// A shift-register scoreboard tracks loads that have left EX but cannot be
// forwarded yet. Stall, bubble and flush controls are decoded combinationally
// from that state. Saturating counters record the stall, flush and
// memory-wait cycles.
module hazard_scoreboard #(
   parameter int REG_IDX_W = 5,
   parameter int LOAD_LAT  = 1,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic                 ex_valid,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_is_load,
   input  logic                 ex_redirect,
   input  logic                 mem_done,
   input  logic                 cnt_clear,
   output logic                 pc_enable,
   output logic                 if_id_enable,
   output logic                 if_id_clear,
   output logic                 id_ex_enable,
   output logic                 id_ex_clear,
   output logic                 ex_mem_enable,
   output logic                 mem_wb_enable,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic [CNT_W-1:0]     memwait_cnt
);

   // With LOAD_LAT=1 there are no entries; one always-invalid slot keeps the
   // array shapes legal and the match logic uniform.
   localparam int N_ENT = LOAD_LAT - 1;
   localparam int N_ARR = (N_ENT > 0) ? N_ENT : 1;

   logic                 sb_v_q  [N_ARR];
   logic [REG_IDX_W-1:0] sb_rd_q [N_ARR];

   logic                 rs1_match;
   logic                 rs2_match;
   logic                 hazard;
   logic                 sel_freeze;
   logic                 sel_flush;
   logic                 sel_stall;
   logic [2:0]           cnt_hit;
   logic [2:0][CNT_W-1:0] cnt_all;

   generate
      if (N_ENT > 0) begin : g_sb
         logic                 sb_v_d  [N_ENT];
         logic [REG_IDX_W-1:0] sb_rd_d [N_ENT];

         // Shift loads down the scoreboard whenever the pipe advances; hold on memory wait
         always_comb begin
            for (int i = 0; i < N_ENT; i++) begin
               sb_v_d[i]  = sb_v_q[i];
               sb_rd_d[i] = sb_rd_q[i];
            end
            if (mem_done) begin
               sb_v_d[0]  = ex_valid & ex_is_load & (ex_rd != '0);
               sb_rd_d[0] = ex_rd;
               for (int i = 1; i < N_ENT; i++) begin
                  sb_v_d[i]  = sb_v_q[i-1];
                  sb_rd_d[i] = sb_rd_q[i-1];
               end
            end
         end

         // Scoreboard register; reset drops every pending load
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < N_ENT; i++) begin
                  sb_v_q[i]  <= 1'b0;
                  sb_rd_q[i] <= '0;
               end
            end else begin
               for (int i = 0; i < N_ENT; i++) begin
                  sb_v_q[i]  <= sb_v_d[i];
                  sb_rd_q[i] <= sb_rd_d[i];
               end
            end
         end
      end else begin : g_no_sb
         assign sb_v_q[0]  = 1'b0;
         assign sb_rd_q[0] = '0;
      end
   endgenerate

   // Compare ID sources against the EX load and every pending scoreboard entry
   always_comb begin
      rs1_match = ex_valid & ex_is_load & (ex_rd == id_rs1);
      rs2_match = ex_valid & ex_is_load & (ex_rd == id_rs2);
      for (int i = 0; i < N_ARR; i++) begin
         rs1_match = rs1_match | (sb_v_q[i] & (sb_rd_q[i] == id_rs1));
         rs2_match = rs2_match | (sb_v_q[i] & (sb_rd_q[i] == id_rs2));
      end
      hazard = id_valid &
               ((id_use_rs1 & (id_rs1 != '0) & rs1_match) |
                (id_use_rs2 & (id_rs2 != '0) & rs2_match));
   end

   // Priority decode: freeze, then redirect flush, then load-use bubble, else run
   always_comb begin
      sel_freeze    = 1'b0;
      sel_flush     = 1'b0;
      sel_stall     = 1'b0;
      pc_enable     = 1'b1;
      if_id_enable  = 1'b1;
      if_id_clear   = 1'b0;
      id_ex_enable  = 1'b1;
      id_ex_clear   = 1'b0;
      ex_mem_enable = 1'b1;
      mem_wb_enable = 1'b1;
      if (!mem_done) begin
         sel_freeze    = 1'b1;
         pc_enable     = 1'b0;
         if_id_enable  = 1'b0;
         id_ex_enable  = 1'b0;
         ex_mem_enable = 1'b0;
         mem_wb_enable = 1'b0;
      end else if (ex_redirect) begin
         // The ID instruction is wrong-path, so flushing beats a load-use stall
         sel_flush   = 1'b1;
         if_id_clear = 1'b1;
         id_ex_clear = 1'b1;
      end else if (hazard) begin
         sel_stall    = 1'b1;
         pc_enable    = 1'b0;
         if_id_enable = 1'b0;
         id_ex_clear  = 1'b1;
      end
   end

   assign cnt_hit = {sel_freeze, sel_flush, sel_stall};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Saturating increment; clear takes priority
         always_comb begin
            cnt_d = cnt_q;
            if (cnt_clear) begin
               cnt_d = '0;
            end else if (cnt_hit[gi] && (cnt_q != '1)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Counter register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign cnt_all[gi] = cnt_q;
      end
   endgenerate

   assign stall_cnt   = cnt_all[0];
   assign flush_cnt   = cnt_all[1];
   assign memwait_cnt = cnt_all[2];

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (LOAD_LAT 1/2/3, the last with
// 4-bit counters) share one stimulus stream; each scenario checks one of them.
module tb_hazard_scoreboard;

   localparam logic [6:0] RUN    = 7'b1101011;
   localparam logic [6:0] STALL  = 7'b0001111;
   localparam logic [6:0] FLUSH  = 7'b1111111;
   localparam logic [6:0] FREEZE = 7'b0000000;

   typedef struct {
      logic       idv;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       exv;
      logic [4:0] exrd;
      logic       exld;
      logic       redir;
      logic       md;
      logic       clr;
   } stim_t;

   typedef struct {
      logic [6:0] ctl;
      int         stall;
      int         flush;
      int         memw;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_is_load;
   logic       ex_redirect, mem_done, cnt_clear;
   logic [4:0] id_rs1, id_rs2, ex_rd;

   logic [6:0]  ctl1, ctl2, ctl3;
   logic [31:0] st1, fl1, mw1, st2, fl2, mw2;
   logic [3:0]  st3, fl3, mw3;

   exp_t exq[$];
   int   total;
   int   bad;

   hazard_scoreboard #(.REG_IDX_W(5), .LOAD_LAT(1), .CNT_W(32)) u_d1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_done(mem_done), .cnt_clear(cnt_clear),
      .pc_enable(ctl1[6]), .if_id_enable(ctl1[5]), .if_id_clear(ctl1[4]),
      .id_ex_enable(ctl1[3]), .id_ex_clear(ctl1[2]), .ex_mem_enable(ctl1[1]),
      .mem_wb_enable(ctl1[0]), .stall_cnt(st1), .flush_cnt(fl1), .memwait_cnt(mw1));

   hazard_scoreboard #(.REG_IDX_W(5), .LOAD_LAT(2), .CNT_W(32)) u_d2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_done(mem_done), .cnt_clear(cnt_clear),
      .pc_enable(ctl2[6]), .if_id_enable(ctl2[5]), .if_id_clear(ctl2[4]),
      .id_ex_enable(ctl2[3]), .id_ex_clear(ctl2[2]), .ex_mem_enable(ctl2[1]),
      .mem_wb_enable(ctl2[0]), .stall_cnt(st2), .flush_cnt(fl2), .memwait_cnt(mw2));

   hazard_scoreboard #(.REG_IDX_W(5), .LOAD_LAT(3), .CNT_W(4)) u_d3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_done(mem_done), .cnt_clear(cnt_clear),
      .pc_enable(ctl3[6]), .if_id_enable(ctl3[5]), .if_id_clear(ctl3[4]),
      .id_ex_enable(ctl3[3]), .id_ex_clear(ctl3[2]), .ex_mem_enable(ctl3[1]),
      .mem_wb_enable(ctl3[0]), .stall_cnt(st3), .flush_cnt(fl3), .memwait_cnt(mw3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic stim_t S(bit idv, int rs1, int rs2, bit u1, bit u2, bit exv,
                               int exrd, bit exld, bit redir, bit md, bit clr);
      stim_t s;
      s.idv = idv; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = u1; s.u2 = u2;
      s.exv = exv; s.exrd = 5'(exrd); s.exld = exld; s.redir = redir;
      s.md = md; s.clr = clr;
      return s;
   endfunction

   function automatic exp_t E(logic [6:0] c, int st, int fl, int mw);
      exp_t e;
      e.ctl = c; e.stall = st; e.flush = fl; e.memw = mw;
      return e;
   endfunction

   function automatic logic [6:0] ctl_of(int sel);
      if (sel == 1) return ctl1;
      if (sel == 2) return ctl2;
      return ctl3;
   endfunction

   function automatic int cnt_of(int sel, int w);
      if (sel == 1) return (w == 0) ? int'(st1) : (w == 1) ? int'(fl1) : int'(mw1);
      if (sel == 2) return (w == 0) ? int'(st2) : (w == 1) ? int'(fl2) : int'(mw2);
      return (w == 0) ? int'(st3) : (w == 1) ? int'(fl3) : int'(mw3);
   endfunction

   task automatic apply(stim_t s);
      id_valid = s.idv; id_rs1 = s.rs1; id_rs2 = s.rs2;
      id_use_rs1 = s.u1; id_use_rs2 = s.u2;
      ex_valid = s.exv; ex_rd = s.exrd; ex_is_load = s.exld;
      ex_redirect = s.redir; mem_done = s.md; cnt_clear = s.clr;
   endtask

   // Drive one cycle of stimulus and queue what the DUT must show for it
   task automatic drive(stim_t s, exp_t e);
      @(posedge clk);
      #1;
      apply(s);
      exq.push_back(e);
   endtask

   // Empty the scoreboards and zero the counters before a scenario
   task automatic settle();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         apply(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      end
   endtask

   task automatic test_reset();
      exp_t e;
      apply(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      rst = 1'b1;
      exq.push_back(E(RUN, 0, 0, 0));
      @(negedge clk);
      e = exq.pop_front();
      for (int sel = 1; sel <= 3; sel++) begin
         total++;
         if (ctl_of(sel) !== e.ctl) begin
            bad++;
            $display("FAIL reset ctl d%0d got=%b exp=%b", sel, ctl_of(sel), e.ctl);
         end
         for (int w = 0; w < 3; w++) begin
            total++;
            if (cnt_of(sel, w) !== 0) begin
               bad++;
               $display("FAIL reset cnt%0d d%0d got=%0d exp=0", w, sel, cnt_of(sel, w));
            end
         end
      end
      $display("reset: ctl=%b/%b/%b", ctl1, ctl2, ctl3);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_lat1();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      settle();
      sq.push_back(S(1, 5, 0, 1, 0, 1, 5, 1, 0, 1, 0)); eq.push_back(E(STALL, 0, 0, 0));
      sq.push_back(S(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN,   1, 0, 0));
      sq.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN,   1, 0, 0));
      for (int k = 0; k < sq.size(); k++) begin
         drive(sq[k], eq[k]);
         @(negedge clk);
         e = exq.pop_front();
         total += 2;
         if (ctl_of(1) !== e.ctl) begin
            bad++;
            $display("FAIL lat1 ctl row%0d got=%b exp=%b", k, ctl_of(1), e.ctl);
         end
         if (cnt_of(1, 0) !== e.stall) begin
            bad++;
            $display("FAIL lat1 stall_cnt row%0d got=%0d exp=%0d", k, cnt_of(1, 0), e.stall);
         end
         $display("lat1 row%0d: ctl=%b stall=%0d", k, ctl_of(1), cnt_of(1, 0));
      end
   endtask

   task automatic test_lat3();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      settle();
      // dependent instruction directly behind the load (rs2)
      sq.push_back(S(1, 3, 7, 1, 1, 1, 7, 1, 0, 1, 0)); eq.push_back(E(STALL, 0, 0, 0));
      sq.push_back(S(1, 3, 7, 1, 1, 0, 0, 0, 0, 1, 0)); eq.push_back(E(STALL, 1, 0, 0));
      sq.push_back(S(1, 3, 7, 1, 1, 0, 0, 0, 0, 1, 0)); eq.push_back(E(STALL, 2, 0, 0));
      sq.push_back(S(1, 3, 7, 1, 1, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN,   3, 0, 0));
      // dependent instruction two behind the load
      sq.push_back(S(1, 1, 0, 1, 0, 1, 7, 1, 0, 1, 0)); eq.push_back(E(RUN,   3, 0, 0));
      sq.push_back(S(1, 7, 0, 1, 0, 1, 1, 0, 0, 1, 0)); eq.push_back(E(STALL, 3, 0, 0));
      sq.push_back(S(1, 7, 0, 1, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(STALL, 4, 0, 0));
      sq.push_back(S(1, 7, 0, 1, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN,   5, 0, 0));
      for (int k = 0; k < sq.size(); k++) begin
         drive(sq[k], eq[k]);
         @(negedge clk);
         e = exq.pop_front();
         total += 2;
         if (ctl_of(3) !== e.ctl) begin
            bad++;
            $display("FAIL lat3 ctl row%0d got=%b exp=%b", k, ctl_of(3), e.ctl);
         end
         if (cnt_of(3, 0) !== e.stall) begin
            bad++;
            $display("FAIL lat3 stall_cnt row%0d got=%0d exp=%0d", k, cnt_of(3, 0), e.stall);
         end
         $display("lat3 row%0d: ctl=%b stall=%0d", k, ctl_of(3), cnt_of(3, 0));
      end
   endtask

   task automatic test_x0_filter();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      settle();
      sq.push_back(S(1, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0)); eq.push_back(E(RUN, 0, 0, 0));
      sq.push_back(S(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN, 0, 0, 0));
      sq.push_back(S(1, 5, 0, 0, 1, 1, 5, 1, 0, 1, 0)); eq.push_back(E(RUN, 0, 0, 0));
      sq.push_back(S(1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN, 0, 0, 0));
      sq.push_back(S(0, 5, 0, 1, 0, 1, 5, 1, 0, 1, 0)); eq.push_back(E(RUN, 0, 0, 0));
      for (int k = 0; k < sq.size(); k++) begin
         drive(sq[k], eq[k]);
         @(negedge clk);
         e = exq.pop_front();
         total += 2;
         if (ctl_of(2) !== e.ctl) begin
            bad++;
            $display("FAIL x0 ctl row%0d got=%b exp=%b", k, ctl_of(2), e.ctl);
         end
         if (cnt_of(2, 0) !== e.stall) begin
            bad++;
            $display("FAIL x0 stall_cnt row%0d got=%0d exp=%0d", k, cnt_of(2, 0), e.stall);
         end
         $display("x0 row%0d: ctl=%b", k, ctl_of(2));
      end
   endtask

   task automatic test_redirect();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      settle();
      sq.push_back(S(1, 5, 0, 1, 0, 1, 5, 1, 1, 1, 0)); eq.push_back(E(FLUSH,  0, 0, 0));
      sq.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN,    0, 1, 0));
      sq.push_back(S(1, 2, 0, 1, 0, 1, 3, 0, 1, 0, 0)); eq.push_back(E(FREEZE, 0, 1, 0));
      sq.push_back(S(1, 2, 0, 1, 0, 1, 3, 0, 1, 1, 0)); eq.push_back(E(FLUSH,  0, 1, 1));
      sq.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN,    0, 2, 1));
      for (int k = 0; k < sq.size(); k++) begin
         drive(sq[k], eq[k]);
         @(negedge clk);
         e = exq.pop_front();
         total += 4;
         if (ctl_of(2) !== e.ctl) begin
            bad++;
            $display("FAIL redirect ctl row%0d got=%b exp=%b", k, ctl_of(2), e.ctl);
         end
         if (cnt_of(2, 0) !== e.stall) begin
            bad++;
            $display("FAIL redirect stall_cnt row%0d got=%0d exp=%0d", k, cnt_of(2, 0), e.stall);
         end
         if (cnt_of(2, 1) !== e.flush) begin
            bad++;
            $display("FAIL redirect flush_cnt row%0d got=%0d exp=%0d", k, cnt_of(2, 1), e.flush);
         end
         if (cnt_of(2, 2) !== e.memw) begin
            bad++;
            $display("FAIL redirect memwait_cnt row%0d got=%0d exp=%0d", k, cnt_of(2, 2), e.memw);
         end
         $display("redirect row%0d: ctl=%b flush=%0d", k, ctl_of(2), cnt_of(2, 1));
      end
   endtask

   task automatic test_memwait();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      settle();
      sq.push_back(S(1, 9, 0, 1, 0, 1, 9, 1, 0, 1, 0)); eq.push_back(E(STALL, 0, 0, 0));
      for (int k = 0; k < 4; k++) begin
         sq.push_back(S(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0)); eq.push_back(E(FREEZE, 1, 0, k));
      end
      sq.push_back(S(1, 9, 0, 1, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(STALL, 1, 0, 4));
      sq.push_back(S(1, 9, 0, 1, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN,   2, 0, 4));
      for (int k = 0; k < sq.size(); k++) begin
         drive(sq[k], eq[k]);
         @(negedge clk);
         e = exq.pop_front();
         total += 3;
         if (ctl_of(2) !== e.ctl) begin
            bad++;
            $display("FAIL memwait ctl row%0d got=%b exp=%b", k, ctl_of(2), e.ctl);
         end
         if (cnt_of(2, 0) !== e.stall) begin
            bad++;
            $display("FAIL memwait stall_cnt row%0d got=%0d exp=%0d", k, cnt_of(2, 0), e.stall);
         end
         if (cnt_of(2, 2) !== e.memw) begin
            bad++;
            $display("FAIL memwait memwait_cnt row%0d got=%0d exp=%0d", k, cnt_of(2, 2), e.memw);
         end
         $display("memwait row%0d: ctl=%b memwait=%0d", k, ctl_of(2), cnt_of(2, 2));
      end
   endtask

   task automatic test_saturate();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      settle();
      for (int k = 0; k < 20; k++) begin
         sq.push_back(S(1, 4, 0, 1, 0, 1, 4, 1, 0, 1, 0));
         eq.push_back(E(STALL, (k > 15) ? 15 : k, 0, 0));
      end
      sq.push_back(S(1, 4, 0, 1, 0, 1, 4, 1, 0, 1, 1)); eq.push_back(E(STALL, 15, 0, 0));
      sq.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(E(RUN,    0, 0, 0));
      for (int k = 0; k < sq.size(); k++) begin
         drive(sq[k], eq[k]);
         @(negedge clk);
         e = exq.pop_front();
         total += 2;
         if (ctl_of(3) !== e.ctl) begin
            bad++;
            $display("FAIL saturate ctl row%0d got=%b exp=%b", k, ctl_of(3), e.ctl);
         end
         if (cnt_of(3, 0) !== e.stall) begin
            bad++;
            $display("FAIL saturate stall_cnt row%0d got=%0d exp=%0d", k, cnt_of(3, 0), e.stall);
         end
         $display("saturate row%0d: stall=%0d", k, cnt_of(3, 0));
      end
   endtask

   task automatic test_reset_mid_stall();
      exp_t e;
      settle();
      drive(S(1, 6, 0, 1, 0, 1, 6, 1, 0, 1, 0), E(STALL, 0, 0, 0));
      @(negedge clk);
      e = exq.pop_front();
      total++;
      if (ctl3 !== e.ctl) begin
         bad++;
         $display("FAIL rststall pre ctl got=%b exp=%b", ctl3, e.ctl);
      end
      drive(S(1, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0), E(STALL, 1, 0, 0));
      @(negedge clk);
      e = exq.pop_front();
      total += 2;
      if (ctl3 !== e.ctl) begin
         bad++;
         $display("FAIL rststall stalled ctl got=%b exp=%b", ctl3, e.ctl);
      end
      if (int'(st3) !== e.stall) begin
         bad++;
         $display("FAIL rststall stalled stall_cnt got=%0d exp=%0d", st3, e.stall);
      end
      // reset asserted mid-cycle while the dependent instruction is still in ID
      drive(S(1, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0), E(RUN, 0, 0, 0));
      rst = 1'b1;
      #1;
      e = exq.pop_front();
      total += 2;
      if (ctl3 !== e.ctl) begin
         bad++;
         $display("FAIL rststall in-reset ctl got=%b exp=%b", ctl3, e.ctl);
      end
      if (int'(st3) !== e.stall) begin
         bad++;
         $display("FAIL rststall in-reset stall_cnt got=%0d exp=%0d", st3, e.stall);
      end
      $display("rststall in reset: ctl=%b stall=%0d", ctl3, st3);
      drive(S(1, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0), E(RUN, 0, 0, 0));
      rst = 1'b0;
      @(negedge clk);
      e = exq.pop_front();
      total++;
      if (ctl3 !== e.ctl) begin
         bad++;
         $display("FAIL rststall after ctl got=%b exp=%b", ctl3, e.ctl);
      end
      $display("rststall after reset: ctl=%b", ctl3);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      test_reset();
      test_lat1();
      test_lat3();
      test_x0_filter();
      test_redirect();
      test_memwait();
      test_saturate();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
